gals_producer: RTL and testbench

//  Producer side of the GALS producer/consumer link. Consumes the 1-cycle
//  `rising` pulse from the debounced button edge detector. Each pulse queues
//  one transfer. Transfers go out one at a time as 8-bit sequence numbers over
//  a 4-phase req/ack handshake to the consumer clock domain.
//  The ack input is asynchronous and is synchronized internally.

---
 rtl/gals_producer_pkg.sv | 13 +
 rtl/gals_producer_sync_bit.sv | 24 ++
 rtl/gals_producer.sv | 115 +++++++++++
 tb/tb_gals_producer.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/gals_producer_pkg.sv
// Shared definitions for the GALS producer/consumer link: handshake FSM
// state encoding and the default data width.
package gals_producer_pkg;

    typedef enum logic [1:0] {
        StIdle    = 2'd0,
        StReq     = 2'd1,
        StRelease = 2'd2
    } state_e;

    localparam int unsigned DefaultDataWidth = 8;

endpackage

// File: rtl/gals_producer_sync_bit.sv
// Multi-flop synchronizer for a single asynchronous bit, synchronously
// cleared to 0 by an active-low reset.
module gals_producer_sync_bit #(
    parameter int unsigned STAGES = 2
) (
    input  logic clock_i,
    input  logic reset_ni,
    input  logic d_i,
    output logic q_o
);

    logic [STAGES-1:0] chain_q;

    always_ff @(posedge clock_i) begin
        if (!reset_ni) begin
            chain_q <= '0;
        end else begin
            chain_q <= {chain_q[STAGES-2:0], d_i};
        end
    end

    assign q_o = chain_q[STAGES-1];

endmodule

// File: rtl/gals_producer.sv
// Producer side of the GALS link: queues send pulses and ships them one at a
// time as sequence numbers over a 4-phase req/ack handshake.
module gals_producer
    import gals_producer_pkg::*;
#(
    parameter int unsigned DATA_WIDTH  = DefaultDataWidth,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned QUEUE_DEPTH = 4
) (
    input  logic                                 clock,
    input  logic                                 reset,
    input  logic                                 send,
    input  logic                                 ack,
    output logic                                 req,
    output logic [DATA_WIDTH-1:0]                dout,
    output logic [$clog2(QUEUE_DEPTH+1)-1:0]     pending,
    output logic                                 busy,
    output logic                                 overflow
);

    localparam int unsigned PendW = $clog2(QUEUE_DEPTH + 1);
    localparam logic [PendW-1:0] DepthP = PendW'(QUEUE_DEPTH);

    state_e                  state_q;
    logic                    req_q;
    logic [DATA_WIDTH-1:0]   dout_q;
    logic [DATA_WIDTH-1:0]   seq_q;
    logic [PendW-1:0]        pending_q;
    logic [PendW-1:0]        pending_d;
    logic                    busy_q;
    logic                    overflow_q;

    logic ack_s;
    logic start_from_queue;
    logic direct_start;
    logic enqueue;
    logic drop;

    gals_producer_sync_bit #(
        .STAGES (SYNC_STAGES)
    ) u_ack_sync (
        .clock_i  (clock),
        .reset_ni (reset),
        .d_i      (ack),
        .q_o      (ack_s)
    );

    // A send seen in IDLE with an empty queue is launched directly and never
    // occupies a queue slot; a queue start has priority over a fresh send.
    always_comb begin
        start_from_queue = 1'b0;
        direct_start     = 1'b0;
        enqueue          = 1'b0;
        drop             = 1'b0;
        pending_d        = pending_q;

        start_from_queue = (state_q == StIdle) && (pending_q != '0);
        direct_start     = (state_q == StIdle) && (pending_q == '0) && send;
        enqueue          = send && !direct_start && (start_from_queue || (pending_q < DepthP));
        drop             = send && !direct_start && !start_from_queue && (pending_q == DepthP);
        pending_d        = pending_q + PendW'(enqueue) - PendW'(start_from_queue);
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q    <= StIdle;
            req_q      <= 1'b0;
            dout_q     <= '0;
            seq_q      <= '0;
            pending_q  <= '0;
            busy_q     <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            pending_q <= pending_d;
            if (drop) begin
                overflow_q <= 1'b1;
            end
            case (state_q)
                StIdle: begin
                    if (start_from_queue || direct_start) begin
                        dout_q  <= seq_q;
                        seq_q   <= seq_q + DATA_WIDTH'(1);
                        req_q   <= 1'b1;
                        busy_q  <= 1'b1;
                        state_q <= StReq;
                    end
                end
                StReq: begin
                    if (ack_s) begin
                        req_q   <= 1'b0;
                        state_q <= StRelease;
                    end
                end
                StRelease: begin
                    if (!ack_s) begin
                        busy_q  <= 1'b0;
                        state_q <= StIdle;
                    end
                end
                default: begin
                    req_q   <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign req      = req_q;
    assign dout     = dout_q;
    assign pending  = pending_q;
    assign busy     = busy_q;
    assign overflow = overflow_q;

endmodule

// File: tb/tb_gals_producer.sv
// Directed bench for gals_producer: handshake timing, queueing, overflow,
// sequence wrap, stale-ack immunity and mid-transfer reset.
module tb_gals_producer;

    logic       clock;
    logic       reset;
    logic       send;
    logic       ack;
    logic       req;
    logic [7:0] dout;
    logic [2:0] pending;
    logic       busy;
    logic       overflow;

    int n_tests = 0;
    int n_fail  = 0;

    gals_producer #(
        .DATA_WIDTH  (8),
        .SYNC_STAGES (2),
        .QUEUE_DEPTH (4)
    ) dut (
        .clock    (clock),
        .reset    (reset),
        .send     (send),
        .ack      (ack),
        .req      (req),
        .dout     (dout),
        .pending  (pending),
        .busy     (busy),
        .overflow (overflow)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic wait_req(input logic val, input int limit, input string tag);
        int c = 0;
        while (req !== val && c < limit) begin
            tick();
            c++;
        end
        check(tag, 32'(req), 32'(val));
    endtask

    task automatic wait_busy(input logic val, input int limit, input string tag);
        int c = 0;
        while (busy !== val && c < limit) begin
            tick();
            c++;
        end
        check(tag, 32'(busy), 32'(val));
    endtask

    // Consumer side: acknowledge the current request and finish the handshake.
    task automatic complete(input string tag);
        ack = 1'b1;
        wait_req(1'b0, 12, {tag, "_req_fall"});
        ack = 1'b0;
        wait_busy(1'b0, 12, {tag, "_busy_fall"});
    endtask

    task automatic expect_start(input string tag, input int exp_dout);
        wait_req(1'b1, 12, {tag, "_req_rise"});
        check({tag, "_dout"}, 32'(dout), exp_dout);
    endtask

    initial begin
        reset = 1'b0;
        send  = 1'b0;
        ack   = 1'b0;
        tick(3);
        check("rst_req", 32'(req), 0);
        check("rst_dout", 32'(dout), 0);
        check("rst_pending", 32'(pending), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_overflow", 32'(overflow), 0);
        reset = 1'b1;
        tick();

        // Single transfer with exact handshake latencies.
        send = 1'b1;
        tick();
        send = 1'b0;
        check("t2_req_rise", 32'(req), 1);
        check("t2_dout", 32'(dout), 0);
        check("t2_pending", 32'(pending), 0);
        check("t2_busy", 32'(busy), 1);
        tick(2);
        ack = 1'b1;
        tick(2);
        check("t2_req_hold", 32'(req), 1);
        tick();
        check("t2_req_fall", 32'(req), 0);
        check("t2_busy_release", 32'(busy), 1);
        ack = 1'b0;
        tick(2);
        check("t2_busy_hold", 32'(busy), 1);
        tick();
        check("t2_busy_fall", 32'(busy), 0);

        reset = 1'b0;
        tick();
        reset = 1'b1;
        tick();

        // Six back-to-back sends against a stalled consumer.
        send = 1'b1;
        tick();
        check("t3_first_req", 32'(req), 1);
        check("t3_first_dout", 32'(dout), 0);
        tick(5);
        send = 1'b0;
        check("t3_pending_full", 32'(pending), 4);
        check("t3_overflow", 32'(overflow), 1);
        complete("t3_x0");
        expect_start("t3_x1", 1);
        complete("t3_x1");
        expect_start("t3_x2", 2);
        complete("t3_x2");
        expect_start("t3_x3", 3);
        complete("t3_x3");
        expect_start("t3_x4", 4);
        complete("t3_x4");
        tick(4);
        check("t3_no_fifth_req", 32'(req), 0);
        check("t3_no_fifth_busy", 32'(busy), 0);
        check("t3_pending_empty", 32'(pending), 0);
        check("t3_dout_last", 32'(dout), 4);
        check("t3_overflow_sticky", 32'(overflow), 1);

        // Reset in the middle of a request with a non-empty queue.
        send = 1'b1;
        tick(3);
        send = 1'b0;
        check("t1_pre_req", 32'(req), 1);
        check("t1_pre_dout", 32'(dout), 5);
        check("t1_pre_pending", 32'(pending), 2);
        reset = 1'b0;
        tick();
        check("t1_req", 32'(req), 0);
        check("t1_dout", 32'(dout), 0);
        check("t1_pending", 32'(pending), 0);
        check("t1_overflow", 32'(overflow), 0);
        check("t1_busy", 32'(busy), 0);
        tick(2);
        reset = 1'b1;
        tick(2);
        check("t1_post_req", 32'(req), 0);

        // Send arriving on the cycle IDLE dequeues.
        send = 1'b1;
        tick(3);
        send = 1'b0;
        check("t4_pending_pre", 32'(pending), 2);
        ack = 1'b1;
        wait_req(1'b0, 12, "t4_req_fall");
        ack = 1'b0;
        wait_busy(1'b0, 12, "t4_idle");
        check("t4_idle_pending", 32'(pending), 2);
        send = 1'b1;
        tick();
        send = 1'b0;
        check("t4_pending_same", 32'(pending), 2);
        check("t4_req", 32'(req), 1);
        check("t4_dout", 32'(dout), 1);
        check("t4_no_drop", 32'(overflow), 0);
        complete("t4_x1");
        expect_start("t4_x2", 2);
        complete("t4_x2");
        expect_start("t4_x3", 3);
        complete("t4_x3");
        tick(3);
        check("t4_drained", 32'(pending), 0);

        // Stale ack while idle must not disturb the next transfer.
        ack = 1'b1;
        tick(4);
        check("t6_idle_busy", 32'(busy), 0);
        check("t6_idle_req", 32'(req), 0);
        ack = 1'b0;
        tick(3);
        send = 1'b1;
        tick();
        send = 1'b0;
        check("t6_req_rise", 32'(req), 1);
        check("t6_dout", 32'(dout), 4);
        tick(5);
        check("t6_req_held", 32'(req), 1);
        complete("t6_x");

        // Sequence wrap across 258 transfers.
        reset = 1'b0;
        tick();
        reset = 1'b1;
        tick();
        for (int i = 0; i < 258; i++) begin
            send = 1'b1;
            tick();
            send = 1'b0;
            expect_start($sformatf("t5_x%0d", i), i % 256);
            complete($sformatf("t5_x%0d", i));
        end
        check("t5_last_dout", 32'(dout), 1);
        check("t5_overflow", 32'(overflow), 0);
        check("t5_pending", 32'(pending), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "simulation timeout");
    end

endmodule
